afifo_reader: RTL
=================

# afifo_reader

Read-side consumer for the asynchronous FIFO. It runs in the `rclk` domain and pops words from the FIFO's show-ahead read port (`r`/`rd`/`rempty`). Popped words go into a 2-entry output buffer that presents a valid/ready stream downstream. A sequence checker verifies that consecutive words increment by one, matching the counting pattern the write side produces in FIFO soak tests.

## Interface
Parameters:
- `Width`, 12, data word width; must match the FIFO `Width`.
- `CheckSeq`, 1, 1 enables the sequence checker; 0 holds `seq_err`/`err_count` at 0.

Ports:
- `rclk`  in  1  read-domain clock.
- `dirclr`  in  1  reset, asynchronous, active-high; clock `rclk`.
- `rempty`  in  1  FIFO empty flag, read-domain; low means `rd` holds a valid head word.
- `rd`  in  Width  FIFO head word (show-ahead), valid while `rempty`=0.
- `r`  out  1  pop strobe to FIFO; one pop per `rclk` edge where `r`=1.
- `out_valid`  out  1  buffer head valid.
- `out_data`  out  Width  buffer head word.
- `out_ready`  in  1  downstream accepts `out_data` on edges where `out_valid` & `out_ready`.
- `seq_err`  out  1  sticky sequence-error flag.
- `err_count`  out  8  sequence mismatches, saturating at 255.
- `word_count`  out  16  words popped since reset, wraps modulo 2^16.

## Operation
- Occupancy state `occ` ∈ {EMPTY(0), ONE(1), FULL(2)} over a 2-entry register buffer with head/tail slots.
- `pop` = `r` = !`dirclr` & !`rempty` & (`occ` != FULL).
  - No combinational path from `out_ready` to `r`.
- `deq` = `out_valid` & `out_ready`.
- Transitions on each `rclk` edge:
  - pop & !deq: `occ`+1.
  - deq & !pop: `occ`−1.
  - pop & deq: `occ` unchanged; the head shifts out and the new word enters the tail (or the head, if `occ`=ONE).
  - neither: hold.
- On pop, `rd` is captured into the buffer on the same edge the FIFO advances its read pointer.
- `out_valid` = (`occ` != EMPTY).
- `out_data` = head slot.
  - Stable while `out_valid` & !`out_ready`.
- Sequence checker (`CheckSeq`=1):
  - Holds register `expected` (Width bits) and flag `primed` (0 after reset).
  - First pop after reset: `expected` ← `rd`+1, `primed` ← 1; no check is made.
  - Each later pop compares `rd` against `expected`.
  - Mismatch: `seq_err` ← 1 (sticky until reset), `err_count` += 1 (saturating).
  - `expected` ← `rd`+1 on every pop, so the checker resyncs and a single gap yields a single error.
  - Arithmetic is modulo 2^Width: 0xFFF followed by 0x000 is correct for Width=12.
- `word_count` += 1 on every pop.

## Timing
- Reset (`dirclr`=1, asynchronous): `occ`=EMPTY, `out_valid`=0, `out_data`=0, `r`=0 (forced regardless of `rempty`), `seq_err`=0, `err_count`=0, `word_count`=0, `primed`=0, `expected`=0.
- Latency: a head word popped at edge k appears on `out_data` with `out_valid`=1 after edge k (one cycle).
- Throughput: 1 word per `rclk` when downstream is always ready.
- Backpressure: with `out_ready`=0 continuously, exactly 2 pops occur, then `r`=0 until a deq.
  - Pops resume on the edge following the first deq.
- FIFO empty: `r` follows `rempty` in the same cycle.
  - `rempty` rising asynchronously mid-cycle deasserts `r` before the edge. The FIFO gates its own pops with the same `rempty`, so no pop is lost or duplicated.
- Reset mid-operation: buffered words are discarded, not replayed. The FIFO is not reset by this block. The first word after release re-primes the checker with no error.
- `err_count` at 255 stays at 255 on further mismatches; `seq_err` stays 1.
- `word_count` 0xFFFF + pop → 0x0000.

## Test plan
- Reset: assert `dirclr` with FIFO non-empty (`rempty`=0) → `r`=0 and all outputs zero; release → `r`=1 on the first cycle.
- Stream: feed 0x000..0x00F with `out_ready`=1 → `out_data` shows 0x000..0x00F in order, 1 per cycle; `seq_err`=0; `word_count`=16.
- Backpressure: `out_ready`=0, FIFO holds 0x010..0x015 → exactly 2 pops, `out_data`=0x010 held; raise `out_ready` → 0x010..0x015 delivered in order, no loss or duplication.
- Wrap: 0xFFE, 0xFFF, 0x000, 0x001 → `seq_err`=0, `err_count`=0.
- Gap: 0x005, 0x006, 0x009, 0x00A → `seq_err`=1 after the edge capturing 0x009; `err_count`=1 and stays 1 after 0x00A.
- Reset mid-operation: `occ`=FULL, pulse `dirclr` → `out_valid`=0 immediately; after release, a first word 0x123 is accepted with `seq_err`=0 and `word_count`=1.

Source files
------------

// File: rtl/afifo_reader.sv
// Read-side consumer for the asynchronous FIFO: pops the show-ahead head word into a
// 2-entry valid/ready output buffer and checks that consecutive words count up by one.
module afifo_reader #(
  parameter int unsigned Width    = 12,
  parameter bit          CheckSeq = 1'b1
) (
  input  logic             rclk,
  input  logic             dirclr,
  input  logic             rempty,
  input  logic [Width-1:0] rd,
  output logic             r,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  input  logic             out_ready,
  output logic             seq_err,
  output logic [7:0]       err_count,
  output logic [15:0]      word_count
);

  localparam int unsigned CntW   = 8;
  localparam int unsigned WordsW = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [Width-1:0]  head_q, head_d;
  logic [Width-1:0]  tail_q, tail_d;
  logic              primed_q, primed_d;
  logic [Width-1:0]  expected_q, expected_d;
  logic              seq_err_q, seq_err_d;
  logic [CntW-1:0]   err_count_q, err_count_d;
  logic [WordsW-1:0] word_count_q, word_count_d;

  logic pop;
  logic deq;

  // Pop decision depends only on occupancy and the FIFO flag, never on out_ready.
  assign pop = !dirclr && !rempty && (occ_q != OCC_FULL);
  assign deq = (occ_q != OCC_EMPTY) && out_ready;

  always_ff @(posedge rclk or posedge dirclr) begin
    if (dirclr) begin
      occ_q        <= OCC_EMPTY;
      head_q       <= '0;
      tail_q       <= '0;
      primed_q     <= 1'b0;
      expected_q   <= '0;
      seq_err_q    <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      primed_q     <= primed_d;
      expected_q   <= expected_d;
      seq_err_q    <= seq_err_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  // Buffer occupancy and slot movement.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (pop) begin
          head_d = rd;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (pop && deq) begin
          head_d = rd;
        end else if (pop) begin
          tail_d = rd;
          occ_d  = OCC_FULL;
        end else if (deq) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (deq) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Sequence checker and pop counter; expected always resyncs to the popped word.
  always_comb begin
    primed_d     = primed_q;
    expected_d   = expected_q;
    seq_err_d    = seq_err_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    if (pop) begin
      word_count_d = word_count_q + WordsW'(1);
      if (CheckSeq) begin
        primed_d   = 1'b1;
        expected_d = rd + Width'(1);
        if (primed_q && (rd != expected_q)) begin
          seq_err_d = 1'b1;
          if (err_count_q != {CntW{1'b1}}) begin
            err_count_d = err_count_q + CntW'(1);
          end
        end
      end
    end
  end

  assign r          = pop;
  assign out_valid  = (occ_q != OCC_EMPTY);
  assign out_data   = head_q;
  assign seq_err    = seq_err_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;

endmodule
